pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter sequencer for the 8-bit core: the consumer of the branch-condition result.
//  Fetches one instruction at a time from instruction memory over a req/ack handshake.
//  Presents the instruction slot to decode/execute, then advances PC on retire: PC+1 or a taken-branch target.
//  Non-pipelined; one instruction in flight; supports stall, halt and a retired-instruction counter.
// PARAMETERS
//  PC_W      8     PC / instruction-address width
//  RESET_PC  0     PC value loaded by reset
//  CNT_W     16    width of retired-instruction counter
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  imem_req       out  1      fetch request to instruction memory
//  imem_addr      out  PC_W   fetch address (= pc)
//  imem_ack       in   1      memory has accepted the request; instruction word valid this cycle
//  instr_valid    out  1      instruction slot occupied (EXEC state)
//  instr_pc       out  PC_W   address of the instruction in the slot
//  stall          in   1      execute not finished; hold slot
//  branch_valid   in   1      slot instruction is a branch (condition evaluated)
//  branch_taken   in   1      condition result; meaningful only with branch_valid
//  branch_target  in   PC_W   target address when taken
//  halt           in   1      slot instruction is HALT
//  halted         out  1      sequencer stopped
//  retired_cnt    out  CNT_W  instructions retired, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, halted=0, retired_cnt=0.
//   All outputs are registered or decoded from registered state only, so each reset value holds while rst_n=0.
//  States: IDLE, FETCH, EXEC, HALTED.
//  IDLE:   unconditional -> FETCH on the next edge after rst_n rises.
//  FETCH:  imem_req=1, imem_addr=pc.
//   - Both are held stable until an edge samples imem_ack=1; then -> EXEC.
//   - Accepted fetch latency: 1 cycle minimum (ack may arrive in the first FETCH cycle); no upper bound.
//   - imem_ack outside FETCH is ignored.
//  EXEC:   instr_valid=1, instr_pc=pc.
//   - stall=1: state and pc held; branch/halt inputs ignored.
//   - stall=0 and halt=1: -> HALTED, pc unchanged. halt wins over a simultaneous branch. Counts as a retire.
//   - stall=0, branch_valid=1, branch_taken=1: pc<=branch_target; -> FETCH.
//   - Otherwise (no branch, or branch not taken): pc<=pc+1 modulo 2^PC_W (0xFF wraps to 0x00); -> FETCH.
//   - Every retire increments retired_cnt by 1; it saturates at all-ones.
//   - Back-to-back throughput: 2 cycles per instruction with ack in the first FETCH cycle.
//  HALTED: halted=1, imem_req=0, instr_valid=0.
//   - Sticky; only rst_n leaves this state.
//  Reset mid-operation: any state returns to IDLE immediately (asynchronous).
//   - imem_req drops in the same cycle; any in-flight fetch is abandoned.
//  branch_target == pc (self-loop) is legal and refetches the same address.
// TESTING
//  1 Reset release, imem_ack tied 1 -> imem_addr 0x00,0x01,0x02 on successive fetches; retired_cnt 0,1,2.
//  2 EXEC at pc=0x10, branch_valid=1, taken=1, target=0x40 -> next FETCH addr 0x40; with taken=0 -> 0x11.
//  3 EXEC at pc=0xFF, no branch -> next imem_addr 0x00, no X, retired_cnt +1.
//  4 stall=1 for 3 cycles with branch_valid/taken asserted -> instr_valid held 3 cycles, pc 0x05 unchanged;
//    on stall=0 the branch is applied once.
//  5 halt=1 and branch taken in the same EXEC at pc=0x20 -> halted=1, imem_req=0 permanently, pc stays 0x20;
//    retired_cnt +1.
//  6 rst_n=0 asynchronously mid-FETCH with ack withheld -> imem_req=0 without a clock edge; after release,
//    fetch restarts at RESET_PC and retired_cnt=0.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_sequencer: fetch/execute program-counter sequencer for the 8-bit core |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pc_sequencer #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  output logic             instr_valid,
  output logic [PC_W-1:0]  instr_pc,
  input  logic             stall,
  input  logic             branch_valid,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             halt,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [PC_W-1:0]  c_reset_pc = RESET_PC[PC_W-1:0];
  localparam logic [PC_W-1:0]  c_pc_one   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;

  // A retire is the single cycle the execute stage releases the slot.
  assign w_retire = (r_state == S_EXEC) && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack) w_state_nxt = S_FETCH + 2'd1;
      S_EXEC: begin
        if (!stall) begin
          w_state_nxt = halt ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH:  imem_req    = 1'b1;
      S_EXEC:   instr_valid = 1'b1;
      S_HALTED: halted      = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
      end
    endcase
  end

  // Halt wins over a simultaneous branch and leaves pc on the HALT address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= c_reset_pc;
    end else if (w_retire && !halt) begin
      if (branch_valid && branch_taken) begin
        r_pc <= branch_target;
      end else begin
        r_pc <= r_pc + c_pc_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_retire && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  assign imem_addr   = r_pc;
  assign instr_pc    = r_pc;
  assign retired_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_sequencer: transaction-level self-checking bench for pc_sequencer  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pc_sequencer;
  localparam int PC_W     = 8;
  localparam int RESET_PC = 0;
  localparam int CNT_W    = 5;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack = 1'b0;
  logic             instr_valid;
  logic [PC_W-1:0]  instr_pc;
  logic             stall = 1'b0;
  logic             branch_valid = 1'b0;
  logic             branch_taken = 1'b0;
  logic [PC_W-1:0]  branch_target = '0;
  logic             halt = 1'b0;
  logic             halted;
  logic [CNT_W-1:0] retired_cnt;

  int checks = 0;
  int errors = 0;
  int exp_pc;
  int exp_cnt;
  int exp_halted;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .stall(stall), .branch_valid(branch_valid), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt), .halted(halted),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack = 1'b0; stall = 1'b0; branch_valid = 1'b0;
    branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
  endtask

  // One fetch transaction: the request must already be up, ack after 'delay' wait cycles.
  task automatic fetch(input int delay);
    int n = 0;
    while (!imem_req && n < 8) begin
      step();
      n++;
    end
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(exp_pc));
    chk("fetch_slot_empty", 32'(instr_valid), 32'd0);
    chk("fetch_cnt", 32'(retired_cnt), 32'(exp_cnt));
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      step();
      chk("fetch_hold_req", 32'(imem_req), 32'd1);
      chk("fetch_hold_addr", 32'(imem_addr), 32'(exp_pc));
    end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("exec_valid", 32'(instr_valid), 32'd1);
    chk("exec_pc", 32'(instr_pc), 32'(exp_pc));
    chk("exec_req_low", 32'(imem_req), 32'd0);
  endtask

  // Stall for 'stalls' cycles with garbage control inputs, then retire with the given controls.
  task automatic retire(input int stalls, input bit h, input bit bv, input bit bt, input int tgt);
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      branch_valid = 1'($urandom); branch_taken = 1'($urandom);
      halt = 1'($urandom); branch_target = 8'($urandom); imem_ack = 1'($urandom);
      step();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc", 32'(instr_pc), 32'(exp_pc));
      chk("stall_cnt", 32'(retired_cnt), 32'(exp_cnt));
    end
    stall = 1'b0; halt = h; branch_valid = bv; branch_taken = bt;
    branch_target = 8'(tgt); imem_ack = 1'($urandom);
    step();
    clear_inputs();
    if (exp_cnt < CNT_MAX) exp_cnt++;
    if (h) exp_halted = 1;
    else if (bv && bt) exp_pc = tgt % 256;
    else exp_pc = (exp_pc + 1) % 256;
    chk("retire_cnt", 32'(retired_cnt), 32'(exp_cnt));
    chk("retire_halted", 32'(halted), 32'(exp_halted));
    chk("retire_req", 32'(imem_req), h ? 32'd0 : 32'd1);
    chk("retire_addr", 32'(imem_addr), 32'(exp_pc));
    chk("retire_slot_empty", 32'(instr_valid), 32'd0);
  endtask

  task automatic jump_to(input int tgt);
    fetch(0);
    retire(0, 1'b0, 1'b1, 1'b1, tgt);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'(RESET_PC));
    exp_pc = RESET_PC; exp_cnt = 0; exp_halted = 0;

    rst_n = 1'b1;
    chk("idle_req", 32'(imem_req), 32'd0);
    step();
    chk("first_fetch_req", 32'(imem_req), 32'd1);

    // Sequential fetches with ack in the first FETCH cycle: 0,1,2.
    repeat (3) begin
      fetch(0);
      retire(0, 1'b0, 1'b0, 1'b0, 0);
    end

    // Taken branch from 0x10 to 0x40, then not-taken from 0x10 to 0x11.
    jump_to(8'h10);
    fetch(0); retire(0, 1'b0, 1'b1, 1'b1, 8'h40);
    chk("branch_taken_addr", 32'(imem_addr), 32'h40);
    jump_to(8'h10);
    fetch(1); retire(0, 1'b0, 1'b1, 1'b0, 8'h40);
    chk("branch_not_taken_addr", 32'(imem_addr), 32'h11);

    // PC wrap from 0xFF.
    jump_to(8'hFF);
    fetch(2); retire(0, 1'b0, 1'b0, 1'b1, 8'h99);
    chk("wrap_addr", 32'(imem_addr), 32'h00);

    // Stall with branch asserted, branch applied once on release.
    jump_to(8'h05);
    fetch(0); retire(3, 1'b0, 1'b1, 1'b1, 8'h33);
    fetch(0); retire(0, 1'b0, 1'b0, 1'b0, 0);
    chk("after_stall_branch", 32'(imem_addr), 32'h34);

    // Self-loop branch refetches the same address.
    fetch(1); retire(1, 1'b0, 1'b1, 1'b1, exp_pc);
    chk("self_loop_addr", 32'(imem_addr), 32'h34);

    // Randomized traffic; the 5-bit counter saturates along the way.
    for (int k = 0; k < 40; k++) begin
      fetch($urandom_range(0, 3));
      retire($urandom_range(0, 2), 1'b0, 1'($urandom), 1'($urandom), $urandom_range(0, 255));
    end
    chk("cnt_saturated", 32'(retired_cnt), 32'(CNT_MAX));

    // Halt together with a taken branch at 0x20.
    jump_to(8'h20);
    fetch(0); retire(0, 1'b1, 1'b1, 1'b1, 8'h77);
    repeat (5) begin
      imem_ack = 1'($urandom); stall = 1'($urandom); halt = 1'($urandom);
      branch_valid = 1'($urandom); branch_taken = 1'($urandom); branch_target = 8'($urandom);
      step();
      chk("halt_sticky", 32'(halted), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      chk("halt_pc", 32'(imem_addr), 32'h20);
    end
    clear_inputs();

    // Asynchronous reset out of HALTED.
    #2 rst_n = 1'b0;
    #1 chk("async_rst_halted", 32'(halted), 32'd0);
    exp_pc = RESET_PC; exp_cnt = 0; exp_halted = 0;
    step();
    rst_n = 1'b1;
    step();
    chk("restart_req", 32'(imem_req), 32'd1);

    // Asynchronous reset mid-FETCH with ack withheld.
    fetch(0); retire(0, 1'b0, 1'b1, 1'b1, 8'h60);
    repeat (2) begin
      step();
      chk("withheld_req", 32'(imem_req), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1 chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_cnt", 32'(retired_cnt), 32'd0);
    chk("async_rst_addr", 32'(imem_addr), 32'(RESET_PC));
    exp_pc = RESET_PC; exp_cnt = 0; exp_halted = 0;
    step();
    rst_n = 1'b1;
    step();
    fetch(1); retire(0, 1'b0, 1'b0, 1'b0, 0);
    chk("post_reset_cnt", 32'(retired_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
